// File: rtl/sys_bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : sys_bus_arb_pkg
// Shared FSM encoding and constants for sys_bus_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package sys_bus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  localparam int          c_DEF_TIMEOUT_CYCLES = 255;
  localparam logic [31:0] c_ERR_RDATA          = 32'h0;

endpackage
`default_nettype wire

// File: rtl/sys_bus_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : sys_bus_arb_rr_pick
// Combinational round-robin picker: first pending bit at or after ptr_i.
// Rev    : 1.0  initial release
// ============================================================================
module sys_bus_arb_rr_pick
  import sys_bus_arb_pkg::*;
#(
  parameter int NUM_HOST = 2,
  parameter int PTR_W    = $clog2(NUM_HOST)
) (
  input  logic [NUM_HOST-1:0] pend_i,
  input  logic [PTR_W-1:0]    ptr_i,
  output logic [NUM_HOST-1:0] winner_o,
  output logic                valid_o
);

  logic [NUM_HOST-1:0] w_rot;
  logic [PTR_W-1:0]    w_off;
  logic [PTR_W:0]      w_sum;
  logic [PTR_W-1:0]    w_idx;

  // Rotating the doubled vector puts the pointer position at bit 0.
  assign w_rot = NUM_HOST'({pend_i, pend_i} >> ptr_i);

  always_comb begin
    w_off = '0;
    for (int j = NUM_HOST - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_off = PTR_W'(j);
      end
    end
  end

  assign w_sum    = {1'b0, ptr_i} + {1'b0, w_off};
  assign w_idx    = (w_sum >= (PTR_W+1)'(NUM_HOST)) ? PTR_W'(w_sum - (PTR_W+1)'(NUM_HOST))
                                                     : PTR_W'(w_sum);
  assign valid_o  = |pend_i;
  assign winner_o = valid_o ? (NUM_HOST'(1) << w_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/sys_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : sys_bus_arbiter
// Round-robin sharing of one system-bus host port, one transaction in flight.
// Optional response timeout enabled by macro SYS_BUS_ARB_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module sys_bus_arbiter
  import sys_bus_arb_pkg::*;
#(
  parameter int NUM_HOST       = 2,
  parameter int TIMEOUT_CYCLES = c_DEF_TIMEOUT_CYCLES
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [NUM_HOST*32-1:0]   req_rw_address_i,
  output logic [NUM_HOST*32-1:0]   req_read_data_o,
  input  logic [NUM_HOST-1:0]      req_read_request_i,
  output logic [NUM_HOST-1:0]      req_read_response_o,
  input  logic [NUM_HOST*32-1:0]   req_write_data_i,
  input  logic [NUM_HOST*4-1:0]    req_write_strobe_i,
  input  logic [NUM_HOST-1:0]      req_write_request_i,
  output logic [NUM_HOST-1:0]      req_write_response_o,
  output logic [31:0]              bus_rw_address_o,
  input  logic [31:0]              bus_read_data_i,
  output logic                     bus_read_request_o,
  input  logic                     bus_read_response_i,
  output logic [31:0]              bus_write_data_o,
  output logic [3:0]               bus_write_strobe_o,
  output logic                     bus_write_request_o,
  input  logic                     bus_write_response_i,
  output logic [NUM_HOST-1:0]      grant_o,
  output logic                     error_o
);

  localparam int PTR_W = $clog2(NUM_HOST);

  arb_state_e          state_q;
  logic [NUM_HOST-1:0] grant_q;
  logic [PTR_W-1:0]    rr_ptr_q;
  logic [PTR_W-1:0]    rr_ptr_d;

  logic [NUM_HOST-1:0] w_pend;
  logic [NUM_HOST-1:0] w_win;
  logic                w_win_vld;
  logic [NUM_HOST-1:0] w_sel;
  logic                w_idle;
  logic                w_wait;
  logic                w_bus_rsp;
  logic                w_rd_done;
  logic                w_wr_done;
  logic                w_done;
  logic [PTR_W-1:0]    w_gnt_idx;

  assign w_pend = req_read_request_i | req_write_request_i;

  sys_bus_arb_rr_pick #(
    .NUM_HOST (NUM_HOST),
    .PTR_W    (PTR_W)
  ) u_pick (
    .pend_i   (w_pend),
    .ptr_i    (rr_ptr_q),
    .winner_o (w_win),
    .valid_o  (w_win_vld)
  );

  // Reset blanks every combinational output so nothing leaks while it is held.
  assign w_idle = (state_q == IDLE) && !reset_i;
  assign w_wait = (state_q == WAIT) && !reset_i;
  assign w_sel  = w_idle ? w_win : (w_wait ? grant_q : '0);

  always_comb begin
    bus_rw_address_o   = '0;
    bus_write_data_o   = '0;
    bus_write_strobe_o = '0;
    for (int k = 0; k < NUM_HOST; k++) begin
      if (w_sel[k]) begin
        bus_rw_address_o   = bus_rw_address_o   | req_rw_address_i[k*32 +: 32];
        bus_write_data_o   = bus_write_data_o   | req_write_data_i[k*32 +: 32];
        bus_write_strobe_o = bus_write_strobe_o | req_write_strobe_i[k*4 +: 4];
      end
    end
  end

  assign bus_read_request_o  = w_idle && |(w_win & req_read_request_i);
  assign bus_write_request_o = w_idle && |(w_win & req_write_request_i);

  assign w_bus_rsp = w_wait && (bus_read_response_i || bus_write_response_i);

  always_comb begin
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_HOST; k++) begin
      if (grant_q[k]) begin
        w_gnt_idx = PTR_W'(k);
      end
    end
  end

  assign rr_ptr_d = (w_gnt_idx == PTR_W'(NUM_HOST - 1)) ? '0 : w_gnt_idx + PTR_W'(1);

`ifdef SYS_BUS_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic        rd_q;
  logic        w_tmo;

  // A real bus response in the expiry cycle takes precedence over the timeout.
  assign w_tmo     = w_wait && !w_bus_rsp && (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign w_rd_done = (w_bus_rsp && bus_read_response_i) || (w_tmo && rd_q);
  assign w_wr_done = (w_bus_rsp && bus_write_response_i) || (w_tmo && !rd_q);
  assign w_done    = w_bus_rsp || w_tmo;
  assign error_o   = w_tmo;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_rd_done      = w_bus_rsp && bus_read_response_i;
  assign w_wr_done      = w_bus_rsp && bus_write_response_i;
  assign w_done         = w_bus_rsp;
  assign error_o        = 1'b0;
`endif

  assign req_read_response_o  = grant_q & {NUM_HOST{w_rd_done}};
  assign req_write_response_o = grant_q & {NUM_HOST{w_wr_done}};
  assign grant_o              = grant_q;

  for (genvar k = 0; k < NUM_HOST; k++) begin : g_rdata
    assign req_read_data_o[k*32 +: 32] = (grant_q[k] && w_bus_rsp && bus_read_response_i)
                                         ? bus_read_data_i : c_ERR_RDATA;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
`ifdef SYS_BUS_ARB_TIMEOUT_EN
      tmo_cnt_q <= '0;
      rd_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (w_win_vld) begin
            state_q <= WAIT;
            grant_q <= w_win;
`ifdef SYS_BUS_ARB_TIMEOUT_EN
            tmo_cnt_q <= '0;
            rd_q      <= |(w_win & req_read_request_i);
`endif
          end
        end
        WAIT: begin
`ifdef SYS_BUS_ARB_TIMEOUT_EN
          tmo_cnt_q <= tmo_cnt_q + 16'd1;
`endif
          if (w_done) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= rr_ptr_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sys_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_sys_bus_arbiter
// Self-checking bench for sys_bus_arbiter (NUM_HOST=2, TIMEOUT_CYCLES=4).
// Rev    : 1.0  initial release
// ============================================================================
module tb_sys_bus_arbiter;

  localparam int NH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NH*32-1:0] req_addr, req_rdata, req_wdata;
  logic [NH*4-1:0]  req_strb;
  logic [NH-1:0]    req_rd, req_rrsp, req_wr, req_wrsp, grant;
  logic [31:0]      bus_addr, bus_rdata, bus_wdata;
  logic [3:0]       bus_strb;
  logic             bus_rd, bus_rrsp, bus_wr, bus_wrsp, err;

  int total = 0;
  int bad   = 0;

  sys_bus_arbiter #(.NUM_HOST(NH), .TIMEOUT_CYCLES(4)) dut (
    .clock_i              (clk),
    .reset_i              (rst),
    .req_rw_address_i     (req_addr),
    .req_read_data_o      (req_rdata),
    .req_read_request_i   (req_rd),
    .req_read_response_o  (req_rrsp),
    .req_write_data_i     (req_wdata),
    .req_write_strobe_i   (req_strb),
    .req_write_request_i  (req_wr),
    .req_write_response_o (req_wrsp),
    .bus_rw_address_o     (bus_addr),
    .bus_read_data_i      (bus_rdata),
    .bus_read_request_o   (bus_rd),
    .bus_read_response_i  (bus_rrsp),
    .bus_write_data_o     (bus_wdata),
    .bus_write_strobe_o   (bus_strb),
    .bus_write_request_o  (bus_wr),
    .bus_write_response_i (bus_wrsp),
    .grant_o              (grant),
    .error_o              (err)
  );

  typedef struct {
    int          host;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] bus_rdata;
    int          lat;
    logic [1:0]  exp_rrsp;
    logic [1:0]  exp_wrsp;
    logic [63:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [1:0]  rrsp;
    logic [1:0]  wrsp;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] rr, input logic [1:0] wr, input logic [63:0] rd, input logic e);
    exp_t x;
    x.rrsp = rr; x.wrsp = wr; x.rdata = rd; x.err = e;
    sb_q.push_back(x);
  endtask

  // Every requester response (or error pulse) must match the next queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if ((|req_rrsp) || (|req_wrsp) || err) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rrsp=%b wrsp=%b err=%b expected none", req_rrsp, req_wrsp, err);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_read",  64'(req_rrsp),  64'(e.rrsp));
        chk("rsp_write", 64'(req_wrsp),  64'(e.wrsp));
        chk("rsp_rdata", 64'(req_rdata), e.rdata);
        chk("rsp_error", 64'(err),       64'(e.err));
      end
    end
  end

  task automatic clr_inputs();
    req_rd = '0; req_wr = '0; bus_rrsp = 1'b0; bus_wrsp = 1'b0; bus_rdata = '0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [NH-1:0] oh;
    oh = NH'(1) << v.host;
    req_rd = '0; req_wr = '0;
    req_rd[v.host] = v.rd;
    req_wr[v.host] = v.wr;
    req_addr[v.host*32 +: 32]  = v.addr;
    req_wdata[v.host*32 +: 32] = v.wdata;
    req_strb[v.host*4 +: 4]    = v.strb;
    @(negedge clk);
    chk($sformatf("v%0d_bus_rd_req", idx), 64'(bus_rd),   64'(v.rd));
    chk($sformatf("v%0d_bus_wr_req", idx), 64'(bus_wr),   64'(v.wr));
    chk($sformatf("v%0d_bus_addr",   idx), 64'(bus_addr), 64'(v.addr));
    if (v.wr) begin
      chk($sformatf("v%0d_bus_wdata", idx), 64'(bus_wdata), 64'(v.wdata));
      chk($sformatf("v%0d_bus_strb",  idx), 64'(bus_strb),  64'(v.strb));
    end
    push_exp(v.exp_rrsp, v.exp_wrsp, v.exp_rdata, 1'b0);
    @(posedge clk); #1;
    for (int c = 0; c < v.lat; c++) begin
      @(negedge clk);
      chk($sformatf("v%0d_wait_rd_req", idx), 64'(bus_rd | bus_wr), 64'(0));
      chk($sformatf("v%0d_wait_grant",  idx), 64'(grant),    64'(oh));
      chk($sformatf("v%0d_wait_addr",   idx), 64'(bus_addr), 64'(v.addr));
      @(posedge clk); #1;
    end
    bus_rrsp  = v.rd;
    bus_wrsp  = v.wr;
    bus_rdata = v.rd ? v.bus_rdata : 32'h0;
    @(negedge clk);
    chk($sformatf("v%0d_rsp_grant", idx), 64'(grant), 64'(oh));
    @(posedge clk); #1;
    clr_inputs();
    @(negedge clk);
    chk($sformatf("v%0d_grant_clear", idx), 64'(grant), 64'(0));
    chk($sformatf("v%0d_sb_empty",    idx), 64'(sb_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[5];
    logic [31:0] d;
    int w;

    vecs[0] = '{host:0, rd:1'b1, wr:1'b0, addr:32'h8000_0000, wdata:32'h0, strb:4'h0,
                bus_rdata:32'h1234_5678, lat:0, exp_rrsp:2'b01, exp_wrsp:2'b00,
                exp_rdata:64'h0000_0000_1234_5678};
    vecs[1] = '{host:1, rd:1'b0, wr:1'b1, addr:32'h0000_1000, wdata:32'hCAFE_BABE, strb:4'b0011,
                bus_rdata:32'h0, lat:0, exp_rrsp:2'b00, exp_wrsp:2'b10, exp_rdata:64'h0};
    vecs[2] = '{host:1, rd:1'b1, wr:1'b0, addr:32'h4000_0010, wdata:32'h0, strb:4'h0,
                bus_rdata:32'hA5A5_0F0F, lat:2, exp_rrsp:2'b10, exp_wrsp:2'b00,
                exp_rdata:64'hA5A5_0F0F_0000_0000};
    vecs[3] = '{host:0, rd:1'b0, wr:1'b1, addr:32'h2000_0004, wdata:32'hDEAD_BEEF, strb:4'b1100,
                bus_rdata:32'h0, lat:1, exp_rrsp:2'b00, exp_wrsp:2'b01, exp_rdata:64'h0};
    vecs[4] = '{host:0, rd:1'b1, wr:1'b1, addr:32'h1111_2222, wdata:32'h3333_4444, strb:4'b1111,
                bus_rdata:32'h5555_6666, lat:0, exp_rrsp:2'b01, exp_wrsp:2'b01,
                exp_rdata:64'h0000_0000_5555_6666};

    rst = 1'b1;
    req_addr = '0; req_wdata = '0; req_strb = '0;
    clr_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_grant",  64'(grant),  64'(0));
    chk("reset_bus_rq", 64'({bus_rd, bus_wr}), 64'(0));
    chk("reset_rsp",    64'({req_rrsp, req_wrsp}), 64'(0));
    chk("reset_rdata",  64'(req_rdata), 64'(0));
    chk("reset_error",  64'(err), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Two requesters hammering from reset: ownership alternates, 2 cycles each.
    req_addr = {32'h0000_0B00, 32'h0000_0A00};
    req_rd   = 2'b11;
    for (int t = 0; t < 4; t++) begin
      w = t % 2;
      d = 32'h1000_0000 + 32'(t);
      @(negedge clk);
      chk($sformatf("cont%0d_bus_rd_req", t), 64'(bus_rd), 64'(1));
      chk($sformatf("cont%0d_addr", t), 64'(bus_addr), (w == 1) ? 64'h0B00 : 64'h0A00);
      push_exp(2'(1 << w), 2'b00, 64'(d) << (w * 32), 1'b0);
      @(posedge clk); #1;
      bus_rrsp  = 1'b1;
      bus_rdata = d;
      @(negedge clk);
      chk($sformatf("cont%0d_grant", t), 64'(grant), 64'(1 << w));
      @(posedge clk); #1;
      bus_rrsp  = 1'b0;
      bus_rdata = '0;
    end
    clr_inputs();
    @(negedge clk);
    chk("cont_sb_empty", 64'(sb_q.size()), 64'(0));
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset while host0 waits; pointer (currently 1) must return to 0.
    req_addr[31:0] = 32'h8000_0000;
    req_addr[63:32] = 32'h9000_0000;
    req_rd = 2'b01;
    @(negedge clk);
    chk("rst_mid_bus_rd_req", 64'(bus_rd), 64'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    req_rd = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_rrsp  = 1'b1;
    bus_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("rst_mid_grant", 64'(grant), 64'(0));
    chk("rst_mid_late_rsp", 64'({req_rrsp, req_wrsp}), 64'(0));
    chk("rst_mid_rdata", 64'(req_rdata), 64'(0));
    @(posedge clk); #1;
    bus_rrsp = 1'b0;
    req_rd = 2'b11;
    @(negedge clk);
    chk("rst_ptr_winner_addr", 64'(bus_addr), 64'h8000_0000);
    push_exp(2'b01, 2'b00, 64'h0000_0000_0BAD_F00D, 1'b0);
    @(posedge clk); #1;
    bus_rrsp  = 1'b1;
    bus_rdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    clr_inputs();
    @(negedge clk);
    chk("rst_sb_empty", 64'(sb_q.size()), 64'(0));

    // Spurious responses while idle, with and without a fresh request.
    @(posedge clk); #1;
    bus_rrsp = 1'b1; bus_wrsp = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("spur_rsp",   64'({req_rrsp, req_wrsp}), 64'(0));
    chk("spur_rdata", 64'(req_rdata), 64'(0));
    chk("spur_grant", 64'(grant), 64'(0));
    @(posedge clk); #1;
    clr_inputs();
    req_wr = 2'b10;
    req_wdata[63:32] = 32'h0102_0304;
    req_strb[7:4] = 4'b1010;
    bus_wrsp = 1'b1;
    @(negedge clk);
    chk("spur_arb_wrsp", 64'(req_wrsp), 64'(0));
    chk("spur_arb_bus_wr", 64'(bus_wr), 64'(1));
    push_exp(2'b00, 2'b10, 64'h0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr_inputs();
    @(negedge clk);
    chk("spur_sb_empty", 64'(sb_q.size()), 64'(0));
    @(posedge clk); #1;

`ifdef SYS_BUS_ARB_TIMEOUT_EN
    // No bus response: the 4th WAIT cycle terminates with an error write response.
    req_wr = 2'b01;
    req_addr[31:0] = 32'h0000_0040;
    req_wdata[31:0] = 32'h5A5A_5A5A;
    req_strb[3:0] = 4'b1111;
    @(negedge clk);
    chk("tmo_bus_wr_req", 64'(bus_wr), 64'(1));
    @(posedge clk); #1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("tmo_early%0d_err", c), 64'(err), 64'(0));
      chk($sformatf("tmo_early%0d_grant", c), 64'(grant), 64'(1));
      @(posedge clk); #1;
    end
    push_exp(2'b00, 2'b01, 64'h0, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    clr_inputs();
    @(negedge clk);
    chk("tmo_grant_clear", 64'(grant), 64'(0));
    chk("tmo_err_clear", 64'(err), 64'(0));
    chk("tmo_sb_empty", 64'(sb_q.size()), 64'(0));
    @(posedge clk); #1;
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
